// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter pixel-write port among NPORTS drawing engines.
// Each port is buffered in a small FIFO, and one pixel per cycle is drained onto the registered VGA bus.
module vga_write_arbiter #(
  parameter int unsigned NPORTS        = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [10*NPORTS-1:0]  req_x,
  input  logic [9*NPORTS-1:0]   req_y,
  input  logic [9*NPORTS-1:0]   req_color,
  input  logic [NPORTS-1:0]     req_write,
  output logic [9:0]            VGA_x,
  output logic [8:0]            VGA_y,
  output logic [8:0]            VGA_color,
  output logic                  VGA_write,
  output logic [NPORTS-1:0]     port_full,
  output logic [NPORTS-1:0]     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(NPORTS);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] color;
  } pixel_t;

  pixel_t          r_mem   [NPORTS][DEPTH];
  logic [AW-1:0]   r_wptr  [NPORTS];
  logic [AW-1:0]   r_rptr  [NPORTS];
  logic [CW-1:0]   r_count [NPORTS];
  logic [PW-1:0]   r_last_grant;

  logic            w_grant_valid;
  logic [PW-1:0]   w_grant_idx;
  logic [PW-1:0]   w_cand;
  logic [NPORTS-1:0] w_pop;
  logic [NPORTS-1:0] w_push;
  logic [CW-1:0]   w_count_next [NPORTS];
  pixel_t          w_head;

  // Arbitration on registered occupancy; descending loops leave the best candidate last.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (r_count[i] != '0) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = PW'(i);
        end
      end
    end else begin
      for (int unsigned off = NPORTS; off >= 1; off--) begin
        w_cand = PW'((32'(r_last_grant) + off) % NPORTS);
        if (r_count[w_cand] != '0) begin
          w_grant_valid = 1'b1;
          w_grant_idx   = w_cand;
        end
      end
    end
  end

  assign w_head = r_mem[w_grant_idx][r_rptr[w_grant_idx]];

  // A full FIFO still accepts a write on the cycle its head is popped.
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_count_next[i] = r_count[i];
      w_pop[i]  = w_grant_valid && (w_grant_idx == PW'(i));
      w_push[i] = req_write[i] && ((r_count[i] != CW'(DEPTH)) || w_pop[i]);
      if (w_push[i] && !w_pop[i]) begin
        w_count_next[i] = r_count[i] + CW'(1);
      end else if (!w_push[i] && w_pop[i]) begin
        w_count_next[i] = r_count[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (Resetn && w_push[i]) begin
        r_mem[i][r_wptr[i]] <= {req_x[10*i +: 10], req_y[9*i +: 9], req_color[9*i +: 9]};
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NPORTS; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_last_grant <= PW'(NPORTS - 1);
      VGA_x        <= '0;
      VGA_y        <= '0;
      VGA_color    <= '0;
      VGA_write    <= 1'b0;
      port_full    <= '0;
      overflow     <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        r_count[i]   <= w_count_next[i];
        port_full[i] <= (w_count_next[i] == CW'(DEPTH));
        if (req_write[i] && !w_push[i]) overflow[i] <= 1'b1;
      end
      VGA_write <= w_grant_valid;
      if (w_grant_valid) begin
        VGA_x        <= w_head.x;
        VGA_y        <= w_head.y;
        VGA_color    <= w_head.color;
        r_last_grant <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: round-robin and fixed-priority instances share stimulus.
// A queue-based reference model fills a scoreboard that is drained as the DUTs emit pixels.
module tb_vga_write_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [39:0] req_x;
  logic [35:0] req_y;
  logic [35:0] req_color;
  logic [3:0]  req_write;

  logic [9:0]  o_x   [2];
  logic [8:0]  o_y   [2];
  logic [8:0]  o_c   [2];
  logic        o_w   [2];
  logic [3:0]  o_full[2];
  logic [3:0]  o_ovf [2];

  vga_write_arbiter #(.NPORTS(4), .DEPTH(DEPTH), .PRIORITY_MODE(0)) u_rr (
    .Clock(Clock), .Resetn(Resetn), .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .req_write(req_write), .VGA_x(o_x[0]), .VGA_y(o_y[0]), .VGA_color(o_c[0]),
    .VGA_write(o_w[0]), .port_full(o_full[0]), .overflow(o_ovf[0]));

  vga_write_arbiter #(.NPORTS(4), .DEPTH(DEPTH), .PRIORITY_MODE(1)) u_fp (
    .Clock(Clock), .Resetn(Resetn), .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .req_write(req_write), .VGA_x(o_x[1]), .VGA_y(o_y[1]), .VGA_color(o_c[1]),
    .VGA_write(o_w[1]), .port_full(o_full[1]), .overflow(o_ovf[1]));

  always #5 Clock = ~Clock;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   check_en = 1'b0;
  int   seq = 0;

  logic [27:0] mq [2][4][$];
  int          mlast [2];
  logic [3:0]  movf  [2];
  logic [27:0] sb_pix  [2][$];
  int          emit_tag [2][4];

  function automatic int model_grant(int m);
    if (m == 1) begin
      for (int i = 0; i < 4; i++) if (mq[m][i].size() != 0) return i;
    end else begin
      for (int off = 1; off <= 4; off++) begin
        int p;
        p = (mlast[m] + off) % 4;
        if (mq[m][p].size() != 0) return p;
      end
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_full(int m);
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[m][i].size() == DEPTH);
    return f;
  endfunction

  // Reference model: grant from pre-edge occupancy, then accept pushes.
  always @(posedge Clock) begin
    for (int m = 0; m < 2; m++) begin
      if (!Resetn) begin
        for (int i = 0; i < 4; i++) mq[m][i].delete();
        mlast[m] <= 3;
        movf[m]  <= '0;
      end else begin
        int g;
        g = model_grant(m);
        if (g >= 0) begin
          sb_pix[m].push_back(mq[m][g].pop_front());
          mlast[m] <= g;
        end
        for (int i = 0; i < 4; i++) begin
          if (req_write[i]) begin
            if (mq[m][i].size() < DEPTH)
              mq[m][i].push_back({req_x[10*i +: 10], req_y[9*i +: 9], req_color[9*i +: 9]});
            else
              movf[m][i] <= 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard drain and flag comparison, away from the active edge.
  always @(negedge Clock) begin
    if (check_en) begin
      for (int m = 0; m < 2; m++) begin
        if (o_w[m] === 1'b1) emit_tag[m][o_c[m][8:7]]++;
        n_checks++;
        assert (o_w[m] === (sb_pix[m].size() != 0)) else begin
          n_errors++;
          $error("FAIL sb_write[%0d] observed=%b expected=%b", m, o_w[m], sb_pix[m].size() != 0);
        end
        if (sb_pix[m].size() != 0) begin
          logic [27:0] e;
          e = sb_pix[m].pop_front();
          n_checks++;
          assert ({o_x[m], o_y[m], o_c[m]} === e) else begin
            n_errors++;
            $error("FAIL sb_pixel[%0d] observed=%h expected=%h", m, {o_x[m], o_y[m], o_c[m]}, e);
          end
        end
        n_checks++;
        assert (o_full[m] === model_full(m)) else begin
          n_errors++;
          $error("FAIL sb_full[%0d] observed=%b expected=%b", m, o_full[m], model_full(m));
        end
        n_checks++;
        assert (o_ovf[m] === movf[m]) else begin
          n_errors++;
          $error("FAIL sb_ovf[%0d] observed=%b expected=%b", m, o_ovf[m], movf[m]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Port tag lives in colour[8:7] so emissions can be attributed without the model.
  task automatic drive_port(input int p);
    req_write[p]        = 1'b1;
    req_x[10*p +: 10]   = 10'(seq);
    req_y[9*p +: 9]     = 9'(p);
    req_color[9*p +: 9] = 9'((p << 7) | (seq & 127));
    seq++;
  endtask

  task automatic load(input logic [3:0] mask);
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) drive_port(p);
      else req_write[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    load(4'hF);
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst_write", 32'(o_w[m]), 0);
      chk("rst_xyc", {o_x[m], o_y[m], o_c[m]}, 0);
      chk("rst_full", 32'(o_full[m]), 0);
      chk("rst_ovf", 32'(o_ovf[m]), 0);
    end
    Resetn = 1'b1;
    load(4'h0);
    tick();
  endtask

  initial begin
    int  n0w;
    bit  full_seen;
    bit  extra;
    bit  seen1;
    logic [3:0] mask;

    Resetn    = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    req_write = '0;
    repeat (2) tick();
    check_en = 1'b1;
    do_reset();

    // single pixel on port 2
    req_write[2]    = 1'b1;
    req_x[29:20]    = 10'd130;
    req_y[26:18]    = 9'd5;
    req_color[26:18] = 9'h1FF;
    tick();
    load(4'h0);
    chk("single_early", 32'(o_w[0]), 0);
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("single_write", 32'(o_w[m]), 1);
      chk("single_x", 32'(o_x[m]), 130);
      chk("single_y", 32'(o_y[m]), 5);
      chk("single_color", 32'(o_c[m]), 32'h1FF);
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("single_once", 32'(o_w[m]), 0);
      chk("single_ovf", 32'(o_ovf[m]), 0);
    end

    // round-robin order and wrap
    do_reset();
    load(4'hF);
    tick();
    load(4'h0);
    for (int p = 0; p < 4; p++) begin
      tick();
      chk("rr_write", 32'(o_w[0]), 1);
      chk("rr_order", 32'(o_c[0][8:7]), p);
    end
    load(4'b1001);
    tick();
    load(4'h0);
    tick();
    chk("rr_wrap_first", 32'(o_c[0][8:7]), 0);
    tick();
    chk("rr_wrap_second", 32'(o_c[0][8:7]), 3);

    // full port 0 plus a write on the cycle it is popped
    do_reset();
    for (int m = 0; m < 2; m++) for (int p = 0; p < 4; p++) emit_tag[m][p] = 0;
    n0w = 0; full_seen = 1'b0; extra = 1'b0;
    for (int c = 0; c < 40 && !extra; c++) begin
      mask = 4'b1110;
      if (o_full[0][0]) begin
        full_seen = 1'b1;
        if (model_grant(0) == 0) begin
          mask[0] = 1'b1;
          extra   = 1'b1;
        end
      end else begin
        mask[0] = 1'b1;
      end
      if (mask[0]) n0w++;
      load(mask);
      tick();
    end
    load(4'h0);
    repeat (30) tick();
    chk("fullpop_seen", 32'(full_seen), 1);
    chk("fullpop_extra", 32'(extra), 1);
    chk("fullpop_ovf0", 32'(o_ovf[0][0]), 0);
    chk("fullpop_count", emit_tag[0][0], n0w);

    // fixed priority: port 0 starves port 3 until it stops
    do_reset();
    for (int c = 0; c < 10; c++) begin
      load(4'b1001);
      tick();
      if (c >= 1) begin
        chk("fp_write", 32'(o_w[1]), 1);
        chk("fp_port0", 32'(o_c[1][8:7]), 0);
      end
    end
    load(4'h0);
    tick();
    chk("fp_port0_last", 32'(o_c[1][8:7]), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fp_drain_write", 32'(o_w[1]), 1);
      chk("fp_drain_port3", 32'(o_c[1][8:7]), 3);
    end
    tick();
    chk("fp_idle", 32'(o_w[1]), 0);

    // overflow on port 1 under load
    do_reset();
    seen1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      load(c < 6 ? 4'b1111 : 4'b1101);
      tick();
      if (o_full[0][1]) seen1 = 1'b1;
    end
    load(4'h0);
    repeat (2) tick();
    chk("ovf_full_seen", 32'(seen1), 1);
    for (int m = 0; m < 2; m++) chk("ovf_sticky", 32'(o_ovf[m][1]), 1);

    // reset while FIFOs still hold data
    Resetn = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("midrst_write", 32'(o_w[m]), 0);
      chk("midrst_full", 32'(o_full[m]), 0);
      chk("midrst_ovf", 32'(o_ovf[m]), 0);
    end
    Resetn = 1'b1;
    repeat (10) begin
      tick();
      for (int m = 0; m < 2; m++) chk("midrst_no_stale", 32'(o_w[m]), 0);
    end

    chk("sb_drained", sb_pix[0].size() + sb_pix[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
